// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket ball scorer.
package cricket_pkg;

    localparam int unsigned BALLS_PER_OVER = 6;

    // Outcome codes reported on last_outcome
    typedef enum logic [3:0] {
        DOT    = 4'd0,
        ONE    = 4'd1,
        TWO    = 4'd2,
        THREE  = 4'd3,
        FOUR   = 4'd4,
        SIX    = 4'd6,
        WICKET = 4'd7,
        WIDE   = 4'd8,
        NOBALL = 4'd9
    } outcome_e;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_UPD   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/cricket_ball_scorer_if.sv
// Bowl request / scoreboard bundle between the game controller and the scorer.
interface cricket_ball_scorer_if #(
    parameter int unsigned SCORE_W = 10,
    parameter int unsigned OVER_W  = 5
);
    logic [3:0]         random_number;
    logic               bowl;
    logic               new_innings;
    logic [SCORE_W-1:0] score;
    logic [3:0]         wickets;
    logic [OVER_W-1:0]  overs;
    logic [2:0]         balls;
    logic [3:0]         last_outcome;
    logic               ball_valid;
    logic               busy;
    logic               innings_done;

    modport master (
        output random_number, bowl, new_innings,
        input  score, wickets, overs, balls, last_outcome, ball_valid, busy, innings_done
    );

    modport slave (
        input  random_number, bowl, new_innings,
        output score, wickets, overs, balls, last_outcome, ball_valid, busy, innings_done
    );
endinterface

// File: rtl/cricket_outcome_decode.sv
// Maps a 4-bit random sample to a ball outcome.
// CRICKET_EXTRAS_EN turns samples 14/15 into WIDE/NOBALL (1 run, not legal);
// otherwise they decode as ONE and DOT legal balls.
module cricket_outcome_decode
    import cricket_pkg::*;
(
    input  logic [3:0] rn_i,
    output outcome_e   code_o,
    output logic [2:0] runs_o,
    output logic       legal_o,
    output logic       is_wicket_o
);

    // Pure lookup from sample to outcome
    always_comb begin
        code_o      = DOT;
        runs_o      = 3'd0;
        legal_o     = 1'b1;
        is_wicket_o = 1'b0;
        case (rn_i)
            4'd4, 4'd5, 4'd6: begin code_o = ONE;   runs_o = 3'd1; end
            4'd7, 4'd8:       begin code_o = TWO;   runs_o = 3'd2; end
            4'd9:             begin code_o = THREE; runs_o = 3'd3; end
            4'd10, 4'd11:     begin code_o = FOUR;  runs_o = 3'd4; end
            4'd12:            begin code_o = SIX;   runs_o = 3'd6; end
            4'd13:            begin code_o = WICKET; is_wicket_o = 1'b1; end
`ifdef CRICKET_EXTRAS_EN
            4'd14:            begin code_o = WIDE;   runs_o = 3'd1; legal_o = 1'b0; end
            4'd15:            begin code_o = NOBALL; runs_o = 3'd1; legal_o = 1'b0; end
`else
            4'd14:            begin code_o = ONE;   runs_o = 3'd1; end
            4'd15:            begin code_o = DOT; end
`endif
            default:          begin code_o = DOT; end
        endcase
    end

endmodule

// File: rtl/cricket_ball_scorer.sv
// Innings scoreboard: accepts a bowl request, decodes the sampled random
// number one cycle later and updates runs/wickets/overs/balls.
// Optional extras decode selected by CRICKET_EXTRAS_EN (see cricket_outcome_decode).
module cricket_ball_scorer
    import cricket_pkg::*;
#(
    parameter int unsigned MAX_OVERS   = 20,
    parameter int unsigned MAX_WICKETS = 10,
    parameter int unsigned SCORE_W     = 10,
    parameter int unsigned OVER_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    cricket_ball_scorer_if.slave  bus
);

    state_e             state_q, state_d;
    logic [3:0]         rn_q, rn_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         wickets_q, wickets_d;
    logic [OVER_W-1:0]  overs_q, overs_d;
    logic [2:0]         balls_q, balls_d;
    outcome_e           last_outcome_q, last_outcome_d;
    logic               ball_valid_q, ball_valid_d;

    outcome_e           code;
    logic [2:0]         runs;
    logic               legal;
    logic               is_wicket;
    logic [SCORE_W:0]   sum;

    cricket_outcome_decode u_decode (
        .rn_i        (rn_q),
        .code_o      (code),
        .runs_o      (runs),
        .legal_o     (legal),
        .is_wicket_o (is_wicket)
    );

    // Next-state: accept in READY, apply in UPD, hold in DONE; new_innings overrides all
    always_comb begin
        state_d        = state_q;
        rn_d           = rn_q;
        score_d        = score_q;
        wickets_d      = wickets_q;
        overs_d        = overs_q;
        balls_d        = balls_q;
        last_outcome_d = last_outcome_q;
        ball_valid_d   = 1'b0;
        sum            = {1'b0, score_q} + {{(SCORE_W-2){1'b0}}, runs};

        case (state_q)
            ST_READY: begin
                if (bus.bowl) begin
                    rn_d    = bus.random_number;
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                score_d        = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                last_outcome_d = code;
                ball_valid_d   = 1'b1;
                if (is_wicket) begin
                    wickets_d = wickets_q + 4'd1;
                end
                if (legal) begin
                    if (balls_q == 3'(BALLS_PER_OVER - 1)) begin
                        balls_d = 3'd0;
                        overs_d = overs_q + 1'b1;
                    end else begin
                        balls_d = balls_q + 3'd1;
                    end
                end
                // Terminal test uses the post-update counters
                if (wickets_d == 4'(MAX_WICKETS) || overs_d == OVER_W'(MAX_OVERS)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        if (bus.new_innings) begin
            state_d        = ST_READY;
            score_d        = '0;
            wickets_d      = '0;
            overs_d        = '0;
            balls_d        = '0;
            last_outcome_d = DOT;
            ball_valid_d   = 1'b0;
        end
    end

    // Scoreboard and FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_READY;
            rn_q           <= '0;
            score_q        <= '0;
            wickets_q      <= '0;
            overs_q        <= '0;
            balls_q        <= '0;
            last_outcome_q <= DOT;
            ball_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rn_q           <= rn_d;
            score_q        <= score_d;
            wickets_q      <= wickets_d;
            overs_q        <= overs_d;
            balls_q        <= balls_d;
            last_outcome_q <= last_outcome_d;
            ball_valid_q   <= ball_valid_d;
        end
    end

    assign bus.score        = score_q;
    assign bus.wickets      = wickets_q;
    assign bus.overs        = overs_q;
    assign bus.balls        = balls_q;
    assign bus.last_outcome = last_outcome_q;
    assign bus.ball_valid   = ball_valid_q;
    assign bus.busy         = (state_q == ST_UPD);
    assign bus.innings_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_cricket_ball_scorer.sv
// Directed bench for cricket_ball_scorer: default instance plus a one-over
// instance and a 5-bit-score instance, all driven by the same stimulus.
module tb_cricket_ball_scorer;
    import cricket_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rn = 4'd0;
    logic       bowl = 1'b0;
    logic       new_inn = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cricket_ball_scorer_if #(.SCORE_W(10), .OVER_W(5)) if1 ();
    cricket_ball_scorer_if #(.SCORE_W(10), .OVER_W(5)) if2 ();
    cricket_ball_scorer_if #(.SCORE_W(5),  .OVER_W(5)) if3 ();

    assign if1.random_number = rn;  assign if1.bowl = bowl;  assign if1.new_innings = new_inn;
    assign if2.random_number = rn;  assign if2.bowl = bowl;  assign if2.new_innings = new_inn;
    assign if3.random_number = rn;  assign if3.bowl = bowl;  assign if3.new_innings = new_inn;

    cricket_ball_scorer #(.MAX_OVERS(20), .MAX_WICKETS(10), .SCORE_W(10), .OVER_W(5))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    cricket_ball_scorer #(.MAX_OVERS(1), .MAX_WICKETS(10), .SCORE_W(10), .OVER_W(5))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    cricket_ball_scorer #(.MAX_OVERS(20), .MAX_WICKETS(10), .SCORE_W(5), .OVER_W(5))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    typedef struct {
        logic [3:0] rn;
        logic [3:0] code;
        int         score;
        int         balls;
        int         wkts;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Request one ball; returns at the negedge where the update is visible
    task automatic deliver(input logic [3:0] r);
        @(negedge clk);
        rn   = r;
        bowl = 1'b1;
        @(negedge clk);
        bowl = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_innings();
        @(negedge clk);
        new_inn = 1'b1;
        @(negedge clk);
        new_inn = 1'b0;
    endtask

    initial begin
        int cnt;

        tbl[0]  = '{4'd0,  DOT,    0, 1, 0};
        tbl[1]  = '{4'd1,  DOT,    0, 1, 0};
        tbl[2]  = '{4'd2,  DOT,    0, 1, 0};
        tbl[3]  = '{4'd3,  DOT,    0, 1, 0};
        tbl[4]  = '{4'd4,  ONE,    1, 1, 0};
        tbl[5]  = '{4'd5,  ONE,    1, 1, 0};
        tbl[6]  = '{4'd6,  ONE,    1, 1, 0};
        tbl[7]  = '{4'd7,  TWO,    2, 1, 0};
        tbl[8]  = '{4'd8,  TWO,    2, 1, 0};
        tbl[9]  = '{4'd9,  THREE,  3, 1, 0};
        tbl[10] = '{4'd10, FOUR,   4, 1, 0};
        tbl[11] = '{4'd11, FOUR,   4, 1, 0};
        tbl[12] = '{4'd12, SIX,    6, 1, 0};
        tbl[13] = '{4'd13, WICKET, 0, 1, 1};
`ifdef CRICKET_EXTRAS_EN
        tbl[14] = '{4'd14, WIDE,   1, 0, 0};
        tbl[15] = '{4'd15, NOBALL, 1, 0, 0};
`else
        tbl[14] = '{4'd14, ONE,    1, 1, 0};
        tbl[15] = '{4'd15, DOT,    0, 1, 0};
`endif

        // Reset state
        @(negedge clk);
        chk("rst_score", if1.score, 0);
        chk("rst_wkts", if1.wickets, 0);
        chk("rst_overs", if1.overs, 0);
        chk("rst_balls", if1.balls, 0);
        chk("rst_last", if1.last_outcome, 0);
        chk("rst_bv", if1.ball_valid, 0);
        chk("rst_busy", if1.busy, 0);
        chk("rst_done", if1.innings_done, 0);
        rst = 1'b0;

        // Reset asserted while the accepted ball is pending in UPD
        @(negedge clk);
        rn = 4'd12;
        bowl = 1'b1;
        @(negedge clk);
        bowl = 1'b0;
        chk("midupd_busy_before", if1.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midupd_score", if1.score, 0);
        chk("midupd_balls", if1.balls, 0);
        chk("midupd_last", if1.last_outcome, 0);
        chk("midupd_bv", if1.ball_valid, 0);
        chk("midupd_busy", if1.busy, 0);
        rst = 1'b0;

        // Single six: latency and one-cycle ball_valid
        @(negedge clk);
        rn = 4'd12;
        bowl = 1'b1;
        @(negedge clk);
        bowl = 1'b0;
        chk("six_score_lat", if1.score, 0);
        chk("six_bv_lat", if1.ball_valid, 0);
        @(negedge clk);
        chk("six_score", if1.score, 6);
        chk("six_balls", if1.balls, 1);
        chk("six_last", if1.last_outcome, SIX);
        chk("six_bv", if1.ball_valid, 1);
        @(negedge clk);
        chk("six_bv_drop", if1.ball_valid, 0);

        // Decode table, each from a fresh innings
        for (int i = 0; i < 16; i++) begin
            start_innings();
            deliver(tbl[i].rn);
            chk($sformatf("tbl%0d_score", i), if1.score, tbl[i].score);
            chk($sformatf("tbl%0d_balls", i), if1.balls, tbl[i].balls);
            chk($sformatf("tbl%0d_code", i), if1.last_outcome, tbl[i].code);
            chk($sformatf("tbl%0d_wkts", i), if1.wickets, tbl[i].wkts);
            chk($sformatf("tbl%0d_bv", i), if1.ball_valid, 1);
        end

        // Bowl held high: one accept every two cycles, six ones make an over
        start_innings();
        rn = 4'd4;
        bowl = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if1.ball_valid) cnt++;
        end
        bowl = 1'b0;
        chk("held_pulses", cnt, 6);
        chk("held_score", if1.score, 6);
        chk("held_overs", if1.overs, 1);
        chk("held_balls", if1.balls, 0);

        // All out, then bowl ignored, then new innings
        start_innings();
        for (int i = 0; i < 10; i++) deliver(4'd13);
        chk("allout_wkts", if1.wickets, 10);
        chk("allout_done", if1.innings_done, 1);
        chk("allout_overs", if1.overs, 1);
        chk("allout_balls", if1.balls, 4);
        deliver(4'd12);
        chk("done_ign_score", if1.score, 0);
        chk("done_ign_bv", if1.ball_valid, 0);
        chk("done_ign_balls", if1.balls, 4);
        chk("done_ign_done", if1.innings_done, 1);
        start_innings();
        chk("clr_wkts", if1.wickets, 0);
        chk("clr_overs", if1.overs, 0);
        chk("clr_balls", if1.balls, 0);
        chk("clr_last", if1.last_outcome, 0);
        chk("clr_done", if1.innings_done, 0);
        chk("clr_busy", if1.busy, 0);

        // new_innings during UPD drops the pending update
        deliver(4'd12);
        @(negedge clk);
        rn = 4'd10;
        bowl = 1'b1;
        @(negedge clk);
        bowl = 1'b0;
        new_inn = 1'b1;
        @(negedge clk);
        new_inn = 1'b0;
        chk("ni_upd_score", if1.score, 0);
        chk("ni_upd_balls", if1.balls, 0);
        chk("ni_upd_bv", if1.ball_valid, 0);
        chk("ni_upd_busy", if1.busy, 0);
        deliver(4'd9);
        chk("ni_after_score", if1.score, 3);

        // Six sixes: one-over innings ends, 5-bit score saturates
        start_innings();
        for (int i = 0; i < 6; i++) deliver(4'd12);
        chk("over_d1_score", if1.score, 36);
        chk("over_d1_overs", if1.overs, 1);
        chk("over_d1_done", if1.innings_done, 0);
        chk("over_d2_score", if2.score, 36);
        chk("over_d2_overs", if2.overs, 1);
        chk("over_d2_done", if2.innings_done, 1);
        chk("sat_d3_score", if3.score, 31);
        deliver(4'd12);
        chk("over_d1_score7", if1.score, 42);
        chk("over_d2_hold", if2.score, 36);
        chk("over_d2_bv", if2.ball_valid, 0);
        chk("sat_d3_hold", if3.score, 31);
        chk("sat_d3_balls", if3.balls, 1);

        // Wicket on the last ball of the last over
        start_innings();
        for (int i = 0; i < 5; i++) deliver(4'd12);
        deliver(4'd13);
        chk("lastball_score", if2.score, 30);
        chk("lastball_wkts", if2.wickets, 1);
        chk("lastball_overs", if2.overs, 1);
        chk("lastball_balls", if2.balls, 0);
        chk("lastball_last", if2.last_outcome, WICKET);
        chk("lastball_done", if2.innings_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
